// File: rtl/ifetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package ifetch_queue_pkg;

    localparam int IFETCH_PC_W    = 30;
    localparam int IFETCH_INSTR_W = 32;

    // The core substitutes this (addi x0,x0,0) when no instruction is valid.
    localparam logic [IFETCH_INSTR_W-1:0] IFETCH_NOP = 32'h0000_0013;

    typedef logic [IFETCH_PC_W-1:0]    pc_t;
    typedef logic [IFETCH_INSTR_W-1:0] instr_t;

    // One prefetch FIFO entry: the word plus the word PC it was fetched from.
    typedef struct packed {
        pc_t    pc;
        instr_t instr;
    } fetch_entry_t;

    localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

    // Word PCs wrap modulo 2^30.
    function automatic pc_t pc_inc(input pc_t pc);
        return pc + pc_t'(1);
    endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// Bus bundle between the fetch queue, the instruction memory and the core.
// Latency: n/a (wires only).
// Backpressure: memory side req/gnt, core side valid/ready; redirect has no backpressure.
//
// master: the fetch queue. slave: the environment (memory + core).
//   req/addr          -> memory request, held while gnt=0
//   gnt/rvalid/rdata  <- memory grant and in-order read return
//   valid/data/pc     -> instruction to the core
//   ready             <- core accepts the instruction
//   redirect/redirect_pc <- flush and restart at a new word PC
interface ifetch_queue_if;
    import ifetch_queue_pkg::*;

    logic   req;
    pc_t    addr;
    logic   gnt;
    logic   rvalid;
    instr_t rdata;

    logic   valid;
    instr_t data;
    pc_t    pc;
    logic   ready;
    logic   redirect;
    pc_t    redirect_pc;

    modport master (
        output req, addr, valid, data, pc,
        input  gnt, rvalid, rdata, ready, redirect, redirect_pc
    );

    modport slave (
        input  req, addr, valid, data, pc,
        output gnt, rvalid, rdata, ready, redirect, redirect_pc
    );

endinterface

// File: rtl/ifetch_queue_fifo_sync.sv
// Generic synchronous FIFO with flush; head word is always visible on pop_dat.
// Latency: push to visible at head is 1 cycle.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
//
// Ports: clk, rst (sync, active-high), flush (sync clear), push/push_dat,
//        pop, pop_dat (head), full, empty, count.
module ifetch_queue_fifo_sync #(
    parameter  int WIDTH = 62,
    parameter  int DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    // A pop frees the slot this cycle, so push into a full FIFO is fine then.
    assign push_ok = push && (!full || pop_ok);
    assign pop_dat = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Storage needs no reset; count/pointers qualify it.
    always_ff @(posedge clk) begin
        if (push_ok && !flush && !rst) begin
            mem[wr_ptr] <= push_dat;
        end
    end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: issues imem requests, buffers PC-tagged words in order.
// Latency: rvalid to instr valid is 1 cycle (0 with IFETCH_BYPASS_EN on an empty FIFO).
// Backpressure: requests stop once buffered + in-flight words reach DEPTH; core stalls via ready.
//
// Ports: clk, rst (sync, active-high), bus (ifetch_queue_if.master).
// Build option: IFETCH_BYPASS_EN forwards a response straight to the core when
// the FIFO is empty.
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int  DEPTH    = 4,
    parameter pc_t RESET_PC = 30'h0
) (
    input  logic            clk,
    input  logic            rst,
    ifetch_queue_if.master  bus
);

    localparam int CW = $clog2(DEPTH + 1);

    pc_t          fetch_pc;
    pc_t          resp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;

    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;
    fetch_entry_t  fifo_head;
    fetch_entry_t  fifo_in;
    logic          fifo_push;
    logic          fifo_pop;

    logic [CW:0]   occupancy;
    logic          issue_ok;
    logic          grant;
    logic          resp_live;
    logic          resp_keep;

    // Every in-flight request has a reserved FIFO slot, so the FIFO can never overflow.
    assign occupancy = {1'b0, fifo_count} + {1'b0, outstanding};
    assign issue_ok  = !rst && !bus.redirect && (occupancy < (CW+1)'(DEPTH));
    assign bus.req   = issue_ok;
    assign bus.addr  = fetch_pc;
    assign grant     = issue_ok && bus.gnt;

    // Stray returns with nothing outstanding (e.g. straight after reset) are ignored.
    assign resp_live = bus.rvalid && (outstanding != '0);
    // A response is kept only if it is not stale and no redirect is flushing this cycle.
    assign resp_keep = resp_live && (drop_cnt == '0) && !bus.redirect;

    assign fifo_in.pc    = resp_pc;
    assign fifo_in.instr = bus.rdata;

`ifdef IFETCH_BYPASS_EN
    logic bypass_vld;

    assign bypass_vld = resp_keep && fifo_empty;

    always_comb begin
        bus.valid = 1'b0;
        bus.data  = fifo_head.instr;
        bus.pc    = fifo_head.pc;
        fifo_push = resp_keep;
        fifo_pop  = 1'b0;
        if (!rst) begin
            if (!fifo_empty) begin
                bus.valid = 1'b1;
                fifo_pop  = bus.ready;
            end else if (bypass_vld) begin
                bus.valid = 1'b1;
                bus.data  = bus.rdata;
                bus.pc    = resp_pc;
                // Consumed directly by the core: nothing to buffer.
                fifo_push = !bus.ready;
            end
        end
    end
`else
    always_comb begin
        bus.valid = !rst && !fifo_empty;
        bus.data  = fifo_head.instr;
        bus.pc    = fifo_head.pc;
        fifo_push = resp_keep;
        fifo_pop  = bus.valid && bus.ready;
    end
`endif

    ifetch_queue_fifo_sync #(
        .WIDTH (FETCH_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (bus.redirect),
        .push     (fifo_push),
        .push_dat (fifo_in),
        .pop      (fifo_pop),
        .pop_dat  (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CW'(grant) - CW'(resp_live);
            if (bus.redirect) begin
                fetch_pc <= bus.redirect_pc;
                resp_pc  <= bus.redirect_pc;
                // No request issues on a redirect cycle, so whatever is still
                // outstanding after this cycle's return is stale. Responses that
                // were already marked stale are part of outstanding, hence no
                // accumulation on top of drop_cnt.
                drop_cnt <= outstanding - CW'(resp_live);
            end else begin
                if (grant) begin
                    fetch_pc <= pc_inc(fetch_pc);
                end
                if (resp_keep) begin
                    resp_pc <= pc_inc(resp_pc);
                end
                if (resp_live && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
            end
        end
    end

    a_rvalid_expected : assert property (@(posedge clk) disable iff (rst)
        bus.rvalid |-> (outstanding != '0));

    a_drop_bounded : assert property (@(posedge clk) disable iff (rst)
        drop_cnt <= outstanding);

    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        fifo_push |-> (!fifo_full || fifo_pop || bus.redirect));

endmodule
